// File: rtl/contactor_sequencer.sv
// contactor_sequencer
//   Drives the precharge and main contactors of a battery pack in response
//   to the pack fault FSM and a host enable. The normal sequence is
//   OPEN -> PRECHARGE -> CLOSING -> CLOSED -> OPENING -> OPEN. Every
//   transition that depends on contactor feedback has a timeout. A trip
//   (fault or shutdown) forces an orderly open and latches a cause code.
//   A latched cause parks the block in LOCKOUT until the host clears it.
//
// Optional build macro: CONTACTOR_FB_SYNC_EN
//   When defined, main_fb, pre_fb and precharge_done each pass through a
//   2-flop synchronizer (reset to 0) before use.
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-high reset
//   fault_state    in   [1:0] 00 NORMAL, 01 WARNING, 1x FAULT
//   shutdown_req   in   hard shutdown request
//   enable_req     in   host connect request (level)
//   precharge_done in   bus voltage inside the precharge window
//   main_fb        in   main contactor aux feedback, 1 = closed
//   pre_fb         in   precharge contactor aux feedback, 1 = closed
//   clear_latch    in   host lockout clear (single-cycle pulse)
//   pre_close      out  precharge contactor drive
//   main_close     out  main contactor drive
//   ready          out  pack connected (CLOSED)
//   warn           out  CLOSED while fault_state is WARNING
//   seq_state      out  [2:0] 0 OPEN,1 PRECHARGE,2 CLOSING,3 CLOSED,
//                       4 OPENING,5 LOCKOUT
//   fault_code     out  [2:0] latched trip cause, 0 = none
module contactor_sequencer #(
   parameter int PRECHARGE_TIMEOUT = 100,
   parameter int FB_TIMEOUT        = 20,
   parameter int TIMER_W           = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] fault_state,
   input  logic       shutdown_req,
   input  logic       enable_req,
   input  logic       precharge_done,
   input  logic       main_fb,
   input  logic       pre_fb,
   input  logic       clear_latch,
   output logic       pre_close,
   output logic       main_close,
   output logic       ready,
   output logic       warn,
   output logic [2:0] seq_state,
   output logic [2:0] fault_code
);

   typedef enum logic [2:0] {
      ST_OPEN      = 3'd0,
      ST_PRECHARGE = 3'd1,
      ST_CLOSING   = 3'd2,
      ST_CLOSED    = 3'd3,
      ST_OPENING   = 3'd4,
      ST_LOCKOUT   = 3'd5
   } state_t;

   localparam logic [2:0] CODE_NONE   = 3'd0;
   localparam logic [2:0] CODE_FAULT  = 3'd1;
   localparam logic [2:0] CODE_SHDN   = 3'd2;
   localparam logic [2:0] CODE_PCHG_T = 3'd3;
   localparam logic [2:0] CODE_CLOSE  = 3'd4;
   localparam logic [2:0] CODE_WELD   = 3'd5;

   localparam logic [TIMER_W-1:0] PCHG_LAST = TIMER_W'(PRECHARGE_TIMEOUT - 1);
   localparam logic [TIMER_W-1:0] FB_LAST   = TIMER_W'(FB_TIMEOUT - 1);

   state_t             state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [2:0]         code_q, code_d;
   logic               main_fb_prev_q;

   logic main_fb_s, pre_fb_s, pchg_done_s;

`ifdef CONTACTOR_FB_SYNC_EN
   logic [2:0] sync1_q, sync2_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 3'b000;
         sync2_q <= 3'b000;
      end else begin
         sync1_q <= {main_fb, pre_fb, precharge_done};
         sync2_q <= sync1_q;
      end
   end
   assign {main_fb_s, pre_fb_s, pchg_done_s} = sync2_q;
`else
   assign main_fb_s   = main_fb;
   assign pre_fb_s    = pre_fb;
   assign pchg_done_s = precharge_done;
`endif

   logic       trip;
   logic [2:0] trip_code;
   logic       main_fb_fall;

   assign trip         = shutdown_req | fault_state[1];
   // Shutdown outranks FAULT when both are present.
   assign trip_code    = shutdown_req ? CODE_SHDN : CODE_FAULT;
   assign main_fb_fall = main_fb_prev_q & ~main_fb_s;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= ST_OPEN;
         timer_q        <= '0;
         code_q         <= CODE_NONE;
         main_fb_prev_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         timer_q        <= timer_d;
         code_q         <= code_d;
         main_fb_prev_q <= main_fb_s;
      end
   end

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      unique case (state_q)
         ST_OPEN: begin
            if (enable_req && !trip) state_d = ST_PRECHARGE;
         end
         ST_PRECHARGE: begin
            if (trip) begin
               state_d = ST_OPENING;
               if (code_q == CODE_NONE) code_d = trip_code;
            end else if (!enable_req) begin
               state_d = ST_OPENING;
            end else if (pchg_done_s) begin
               state_d = ST_CLOSING;
            end else if (timer_q == PCHG_LAST) begin
               state_d = ST_OPENING;
               if (code_q == CODE_NONE) code_d = CODE_PCHG_T;
            end
         end
         ST_CLOSING: begin
            if (trip) begin
               state_d = ST_OPENING;
               if (code_q == CODE_NONE) code_d = trip_code;
            end else if (main_fb_s) begin
               state_d = ST_CLOSED;
            end else if (timer_q == FB_LAST) begin
               state_d = ST_OPENING;
               if (code_q == CODE_NONE) code_d = CODE_CLOSE;
            end
         end
         ST_CLOSED: begin
            if (trip) begin
               state_d = ST_OPENING;
               if (code_q == CODE_NONE) code_d = trip_code;
            end else if (!enable_req) begin
               state_d = ST_OPENING;
            end else if (main_fb_fall) begin
               state_d = ST_OPENING;
               if (code_q == CODE_NONE) code_d = CODE_CLOSE;
            end
         end
         ST_OPENING: begin
            if (!main_fb_s && !pre_fb_s) begin
               state_d = (code_q != CODE_NONE) ? ST_LOCKOUT : ST_OPEN;
            end else if (timer_q == FB_LAST) begin
               // A stuck contactor is the most serious cause; it replaces
               // whatever was latched before.
               state_d = ST_LOCKOUT;
               code_d  = CODE_WELD;
            end
         end
         ST_LOCKOUT: begin
            if (clear_latch && !trip && fault_state == 2'b00) begin
               state_d = ST_OPEN;
               code_d  = CODE_NONE;
            end
         end
         default: begin
            state_d = ST_OPEN;
         end
      endcase

      if (state_d != state_q)  timer_d = '0;
      else if (timer_q == '1)  timer_d = timer_q;
      else                     timer_d = timer_q + TIMER_W'(1);
   end

   assign pre_close  = (state_q == ST_PRECHARGE) | (state_q == ST_CLOSING);
   assign main_close = (state_q == ST_CLOSING) | (state_q == ST_CLOSED);
   assign ready      = (state_q == ST_CLOSED);
   assign warn       = (state_q == ST_CLOSED) & (fault_state == 2'b01);
   assign seq_state  = state_q;
   assign fault_code = code_q;

endmodule

// File: doc/contactor_sequencer.md
Name: contactor_sequencer

Overview:
- Responder to the pack fault FSM. Consumes its 2-bit fault state and shutdown request, and sequences the precharge and main contactors.
- Sequence is open → precharge → close → hold → open, with feedback-verified transitions and timeouts.
- Any fault or shutdown forces an orderly open. Trips latch into a lockout that only a host clear releases.
- Sits between the fault FSM and the contactor driver pins; status goes to the host/BMS controller.

Parameters:
- PRECHARGE_TIMEOUT, 100: maximum cycles in PRECHARGE waiting for precharge_done.
- FB_TIMEOUT, 20: maximum cycles waiting for contactor feedback in CLOSING or OPENING.
- TIMER_W, 16: width of the state timer. Must hold max(PRECHARGE_TIMEOUT, FB_TIMEOUT).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- fault_state  input  2  fault FSM state: 00 NORMAL, 01 WARNING, 10 FAULT, 11 treated as FAULT.
- shutdown_req  input  1  hard shutdown request from the fault FSM.
- enable_req  input  1  host request to connect the pack (level).
- precharge_done  input  1  bus voltage within precharge window.
- main_fb  input  1  main contactor auxiliary feedback, 1 = closed.
- pre_fb  input  1  precharge contactor auxiliary feedback, 1 = closed.
- clear_latch  input  1  host lockout clear, single-cycle pulse.
- pre_close  output  1  precharge contactor drive.
- main_close  output  1  main contactor drive.
- ready  output  1  pack connected (CLOSED state).
- warn  output  1  in CLOSED with fault_state == WARNING.
- seq_state  output  3  0 OPEN, 1 PRECHARGE, 2 CLOSING, 3 CLOSED, 4 OPENING, 5 LOCKOUT.
- fault_code  output  3  latched trip cause: 0 none, 1 FAULT state, 2 shutdown_req, 3 precharge timeout, 4 close-feedback timeout, 5 weld (open-feedback timeout).

Behaviour:
- Reset (asynchronous):
  - State OPEN; timer and fault_code 0.
  - All outputs 0; seq_state = 0.
- Outputs are decoded combinationally from the state register only (Moore), so drives change the cycle after the triggering input is sampled.
  - pre_close = PRECHARGE | CLOSING.
  - main_close = CLOSING | CLOSED.
  - ready = CLOSED.
  - warn = CLOSED & (fault_state == 01).
- Timer: cleared on every state change; increments each cycle in-state; saturates at all-ones. A timeout fires when timer == LIMIT-1 and the exit condition is still false, so the state is left after exactly LIMIT cycles.
- trip = shutdown_req | fault_state[1].
- Transitions, highest priority first within each state:
  - OPEN:
    - enable_req & !trip → PRECHARGE.
  - PRECHARGE:
    - trip → OPENING, latch cause.
    - !enable_req → OPENING, no cause.
    - precharge_done → CLOSING.
    - timeout → OPENING, code 3.
  - CLOSING:
    - trip → OPENING, latch cause.
    - main_fb → CLOSED.
    - timeout → OPENING, code 4.
  - CLOSED:
    - trip → OPENING, latch cause.
    - !enable_req → OPENING, no cause.
    - main_fb falling while CLOSED → OPENING, code 4.
  - OPENING:
    - !main_fb & !pre_fb → LOCKOUT if fault_code != 0, else OPEN.
    - timeout → LOCKOUT, code 5, overriding any earlier code.
  - LOCKOUT:
    - clear_latch & !trip & fault_state == 00 → OPEN, fault_code cleared.
    - clear_latch under any other condition is ignored.
- Cause latching:
  - If shutdown_req and FAULT are both asserted, code 2 wins.
  - The first non-weld cause holds until cleared; later trips do not overwrite it.
- WARNING alone never opens contactors; it only raises warn in CLOSED.
- enable_req held high in OPEN with no trip re-sequences immediately.
- Reset asserted mid-sequence drops both drives within the reset assertion (asynchronous). After reset the block is in OPEN, not LOCKOUT.

Optional Feature:
- Macro: CONTACTOR_FB_SYNC_EN.
- Defined: main_fb, pre_fb and precharge_done each pass through a 2-flop synchronizer (reset to 0) before use. Feedback-driven transitions occur 2 cycles later; timeout counts are unchanged.
- Undefined: inputs are used directly, and the caller guarantees they are synchronous to clk.

Test Plan:
- Normal connect, fault_state=00:
  - Stimulus: enable_req=1; precharge_done at cycle 10; main_fb at cycle 5 of CLOSING.
  - Required: seq_state 0→1→2→3; pre_close drops in CLOSED; ready=1; fault_code=0.
- Precharge timeout:
  - Stimulus: enable_req=1, precharge_done never asserts.
  - Required: PRECHARGE exits after exactly 100 cycles into OPENING. Feedback low → LOCKOUT with fault_code=3.
- Trip while CLOSED:
  - Stimulus: shutdown_req and fault_state=10 asserted in the same cycle.
  - Required: next cycle main_close=0, seq_state=4, fault_code=2. Feedback low → LOCKOUT.
- Lockout clear:
  - Stimulus: clear_latch pulse while fault_state=10, then a second pulse with fault_state=00.
  - Required: first pulse ignored; second gives seq_state=0, fault_code=0.
- Weld:
  - Stimulus: in OPENING, main_fb stuck at 1.
  - Required: after 20 cycles, LOCKOUT with fault_code=5, overwriting the prior code 1.
- Warning and reset:
  - Stimulus: fault_state=01 in CLOSED, then reset asserted mid-CLOSING.
  - Required: warn=1 with main_close held at 1; on reset, all outputs 0 immediately and state OPEN.
